// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues epoch-tagged word fetches to the I-MMU and queues returned words for decode.
// Define FETCH_PERF_COUNTERS_EN to add the perf_issued_out / perf_dropped_out / perf_stall_out counters.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        fetch_request_ready_in,
   output logic        fetch_request_valid_out,
   output logic [31:0] fetch_request_address_out,
   output logic        fetch_response_ready_out,
   input  logic        fetch_response_valid_in,
   input  logic [31:0] fetch_response_data_in,
   input  logic        redirect_valid_in,
   input  logic [31:0] redirect_address_in,
   output logic        inst_valid_out,
   input  logic        inst_ready_in,
   output logic [31:0] inst_data_out,
   output logic [31:0] inst_pc_out
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0] perf_issued_out,
   output logic [31:0] perf_dropped_out,
   output logic [31:0] perf_stall_out
`endif
);

   localparam int          PW      = $clog2(QUEUE_DEPTH);
   localparam int          CW      = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

   typedef enum logic {
      REQ_IDLE,
      REQ_PENDING
   } reqState_t;

   reqState_t     r_reqState;
   reqState_t     w_reqStateNext;
   logic          w_issue;

   logic [31:0]   r_pc;
   logic [31:0]   r_reqAddr;
   logic          r_epoch;
   logic          r_reqEpoch;

   logic          r_tagEpoch [QUEUE_DEPTH];
   logic [31:0]   r_tagPc    [QUEUE_DEPTH];
   logic [PW-1:0] r_tagWr;
   logic [PW-1:0] r_tagRd;
   logic [CW-1:0] r_tagCount;

   logic [31:0]   r_qData [QUEUE_DEPTH];
   logic [31:0]   r_qPc   [QUEUE_DEPTH];
   logic [PW-1:0] r_qWr;
   logic [PW-1:0] r_qRd;
   logic [CW-1:0] r_qCount;

   logic          w_reqFire;
   logic          w_rspFire;
   logic          w_tagPop;
   logic          w_headEpoch;
   logic [31:0]   w_headPc;
   logic          w_qPush;
   logic          w_qPop;
   logic [CW-1:0] w_tagCountNext;
   logic [CW-1:0] w_qCountNext;
   logic          w_credit;
   logic [31:0]   w_pcBase;
   logic          w_epochNext;

   assign fetch_request_valid_out   = (r_reqState == REQ_PENDING) && !rst_in;
   assign fetch_request_address_out = r_reqAddr;
   assign fetch_response_ready_out  = !rst_in;

   assign w_reqFire   = fetch_request_valid_out && fetch_request_ready_in;
   assign w_rspFire   = fetch_response_valid_in && fetch_response_ready_out;
   assign w_tagPop    = w_rspFire && (r_tagCount != '0);
   assign w_headEpoch = r_tagEpoch[r_tagRd];
   assign w_headPc    = r_tagPc[r_tagRd];

   // A response that coincides with a redirect is judged against the new epoch, so it never survives
   assign w_qPush = w_tagPop && (w_headEpoch == r_epoch) && !redirect_valid_in;

   assign inst_valid_out = (r_qCount != '0) && !rst_in;
   assign inst_data_out  = r_qData[r_qRd];
   assign inst_pc_out    = r_qPc[r_qRd];
   assign w_qPop         = inst_valid_out && inst_ready_in && !redirect_valid_in;

   assign w_tagCountNext = r_tagCount + CW'(w_reqFire) - CW'(w_tagPop);
   assign w_qCountNext   = redirect_valid_in ? '0 : (r_qCount + CW'(w_qPush) - CW'(w_qPop));

   // Credit is judged on next-cycle counts so a handshake can be followed by a new request immediately
   assign w_credit    = ({1'b0, w_tagCountNext} + {1'b0, w_qCountNext}) < DEPTH_W;
   assign w_pcBase    = redirect_valid_in ? (redirect_address_in & ~32'h3) : r_pc;
   assign w_epochNext = r_epoch ^ redirect_valid_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_reqState <= REQ_IDLE;
      end else begin
         r_reqState <= w_reqStateNext;
      end
   end

   always_comb begin
      w_reqStateNext = r_reqState;
      w_issue        = 1'b0;
      case (r_reqState)
         REQ_IDLE: begin
            if (w_credit) begin
               w_reqStateNext = REQ_PENDING;
               w_issue        = 1'b1;
            end
         end
         REQ_PENDING: begin
            if (w_reqFire) begin
               if (w_credit) begin
                  w_issue = 1'b1;
               end else begin
                  w_reqStateNext = REQ_IDLE;
               end
            end
         end
         default: w_reqStateNext = REQ_IDLE;
      endcase
   end

   // r_pc always holds the address the next newly raised request will carry
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pc       <= RESET_PC;
         r_reqAddr  <= RESET_PC;
         r_epoch    <= 1'b0;
         r_reqEpoch <= 1'b0;
      end else begin
         r_epoch <= w_epochNext;
         if (w_issue) begin
            r_reqAddr  <= w_pcBase;
            r_reqEpoch <= w_epochNext;
            r_pc       <= w_pcBase + 32'd4;
         end else begin
            r_pc <= w_pcBase;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_tagWr    <= '0;
         r_tagRd    <= '0;
         r_tagCount <= '0;
      end else begin
         if (w_reqFire) begin
            r_tagWr <= r_tagWr + PW'(1);
         end
         if (w_tagPop) begin
            r_tagRd <= r_tagRd + PW'(1);
         end
         r_tagCount <= w_tagCountNext;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && w_reqFire) begin
         r_tagEpoch[r_tagWr] <= r_reqEpoch;
         r_tagPc[r_tagWr]    <= r_reqAddr;
      end
   end

   // A flush needs only the read pointer to catch up, since nothing is pushed in a redirect cycle
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_qWr    <= '0;
         r_qRd    <= '0;
         r_qCount <= '0;
      end else begin
         if (redirect_valid_in) begin
            r_qRd <= r_qWr;
         end else begin
            if (w_qPush) begin
               r_qWr <= r_qWr + PW'(1);
            end
            if (w_qPop) begin
               r_qRd <= r_qRd + PW'(1);
            end
         end
         r_qCount <= w_qCountNext;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && w_qPush) begin
         r_qData[r_qWr] <= fetch_response_data_in;
         r_qPc[r_qWr]   <= w_headPc;
      end
   end

   // A response with nothing outstanding is a protocol error from the MMU side
   assert property (@(posedge clk_in) disable iff (rst_in) w_rspFire |-> (r_tagCount != '0));

`ifdef FETCH_PERF_COUNTERS_EN
   logic w_stale;
   logic w_stall;

   assign w_stale = w_tagPop && !w_qPush;
   assign w_stall = ((r_reqState == REQ_PENDING) && !fetch_request_ready_in) ||
                    ((r_reqState == REQ_IDLE) && (({1'b0, r_tagCount} + {1'b0, r_qCount}) >= DEPTH_W));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         perf_issued_out  <= '0;
         perf_dropped_out <= '0;
         perf_stall_out   <= '0;
      end else begin
         perf_issued_out  <= perf_issued_out + 32'(w_reqFire);
         perf_dropped_out <= perf_dropped_out + 32'(w_stale);
         perf_stall_out   <= perf_stall_out + 32'(w_stall);
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit: an MMU responder, a transaction-level model and a decode-side monitor.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int          DEPTH    = 4;

   logic        clk;
   logic        rst;
   logic        reqReady;
   logic        reqValid;
   logic [31:0] reqAddr;
   logic        rspReady;
   logic        rspValid;
   logic [31:0] rspData;
   logic        redirValid;
   logic [31:0] redirAddr;
   logic        instValid;
   logic        instReady;
   logic [31:0] instData;
   logic [31:0] instPc;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] perfIssued;
   logic [31:0] perfDropped;
   logic [31:0] perfStall;
`endif

   instruction_fetch_unit #(
      .RESET_PC    (RESET_PC),
      .QUEUE_DEPTH (DEPTH)
   ) dut (
      .clk_in                    (clk),
      .rst_in                    (rst),
      .fetch_request_ready_in    (reqReady),
      .fetch_request_valid_out   (reqValid),
      .fetch_request_address_out (reqAddr),
      .fetch_response_ready_out  (rspReady),
      .fetch_response_valid_in   (rspValid),
      .fetch_response_data_in    (rspData),
      .redirect_valid_in         (redirValid),
      .redirect_address_in       (redirAddr),
      .inst_valid_out            (instValid),
      .inst_ready_in             (instReady),
      .inst_data_out             (instData),
      .inst_pc_out               (instPc)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .perf_issued_out           (perfIssued),
      .perf_dropped_out          (perfDropped),
      .perf_stall_out            (perfStall)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mmuEntry_t;

   typedef struct {
      logic [31:0] addr;
      logic        epoch;
   } tagEntry_t;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
   } instEntry_t;

   mmuEntry_t   mmuQ[$];
   tagEntry_t   tagQ[$];
   instEntry_t  expQ[$];

   int          passed    = 0;
   int          total     = 0;
   int          cyc       = 0;
   int          lastDue   = 0;
   int          hsCount   = 0;
   int          dropCount = 0;
   int          deqCount  = 0;
   bit          running   = 0;

   logic [31:0] modelPc;
   logic        modelEpoch;
   logic        curTag;
   bit          pendingCarry;
   logic [31:0] prevAddr;

   // The simulated MMU returns a word that is a fixed scramble of its address
   function automatic logic [31:0] mmuData(input logic [31:0] a);
      return (a * 32'h0019_660D) ^ 32'hA5A5_5A5A;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // MMU side bookkeeping: remember accepted fetches in order and retire them as responses are taken
   always @(negedge clk) begin
      if (rst) begin
         mmuQ.delete();
      end else begin
         if (rspValid && rspReady && mmuQ.size() > 0) begin
            mmuQ.pop_front();
         end
         if (reqValid && reqReady) begin
            int due;
            due = cyc + int'($urandom_range(1, 3));
            if (due < lastDue) due = lastDue;
            lastDue = due;
            mmuQ.push_back('{addr: reqAddr, due: due});
         end
      end
      cyc++;
   end

   // Reference model: predicts the request address stream and which responses reach decode
   always @(negedge clk) begin
      #1;
      if (running) begin
         logic      v;
         logic      hs;
         logic      rf;
         tagEntry_t t;
         v  = reqValid;
         hs = reqValid && reqReady;
         rf = rspValid && rspReady;
         if (pendingCarry) begin
            checkOutput("req_hold_valid", 32'(v), 32'd1);
            checkOutput("req_hold_addr", reqAddr, prevAddr);
         end else if (v) begin
            checkOutput("req_addr", reqAddr, modelPc);
            curTag  = modelEpoch;
            modelPc = modelPc + 32'd4;
         end
         checkOutput("credit", 32'((tagQ.size() + expQ.size() + int'(v)) <= DEPTH), 32'd1);
         if (rf && tagQ.size() > 0) begin
            t = tagQ.pop_front();
            if (t.epoch == modelEpoch && !redirValid) begin
               expQ.push_back('{data: mmuData(t.addr), pc: t.addr});
            end else begin
               dropCount++;
            end
         end
         if (hs) begin
            tagQ.push_back('{addr: reqAddr, epoch: curTag});
            hsCount++;
         end
         if (redirValid) begin
            expQ.delete();
            modelEpoch = !modelEpoch;
            modelPc    = {redirAddr[31:2], 2'b00};
         end
         pendingCarry = v && !hs;
         prevAddr     = reqAddr;
      end
   end

   // Decode-side monitor: pops the expected queue whenever the DUT hands over an instruction
   always @(negedge clk) begin
      if (running) begin
         checkOutput("rsp_ready", 32'(rspReady), 32'd1);
         checkOutput("inst_valid", 32'(instValid), 32'(expQ.size() != 0));
         if (instValid && instReady && !redirValid && expQ.size() > 0) begin
            instEntry_t e;
            e = expQ.pop_front();
            checkOutput("inst_data", instData, e.data);
            checkOutput("inst_pc", instPc, e.pc);
            deqCount++;
         end
      end
   end

   task automatic applyStimulus(input int cycles, input int reqPct, input int instPct, input int redirPct);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         reqReady  = ($urandom_range(0, 99) < reqPct);
         instReady = ($urandom_range(0, 99) < instPct);
         if (!redirValid && ($urandom_range(0, 99) < redirPct)) begin
            redirValid = 1'b1;
            case ($urandom_range(0, 3))
               0:       redirAddr = 32'h0000_0203;
               1:       redirAddr = 32'hFFFF_FFF6;
               2:       redirAddr = 32'hFFFF_FFFD;
               default: redirAddr = $urandom;
            endcase
         end else begin
            redirValid = 1'b0;
         end
         if (mmuQ.size() > 0 && mmuQ[0].due <= cyc && $urandom_range(0, 99) < 80) begin
            rspValid = 1'b1;
            rspData  = mmuData(mmuQ[0].addr);
         end else begin
            rspValid = 1'b0;
            rspData  = 32'h0;
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      reqReady     = 1'b0;
      rspValid     = 1'b0;
      rspData      = 32'h0;
      redirValid   = 1'b0;
      redirAddr    = 32'h0;
      instReady    = 1'b0;
      modelPc      = RESET_PC;
      modelEpoch   = 1'b0;
      curTag       = 1'b0;
      pendingCarry = 0;
      prevAddr     = 32'h0;

      repeat (3) begin
         @(negedge clk);
         checkOutput("rst_req_valid", 32'(reqValid), 32'd0);
         checkOutput("rst_rsp_ready", 32'(rspReady), 32'd0);
         checkOutput("rst_inst_valid", 32'(instValid), 32'd0);
      end
      @(posedge clk);
      #1;
      rst     = 1'b0;
      running = 1;

      // Decode stalled: the unit must stop after filling every credit
      applyStimulus(30, 100, 0, 0);
      @(posedge clk);
      #1;
      checkOutput("hold_issued", hsCount, DEPTH);
      checkOutput("hold_req_valid", 32'(reqValid), 32'd0);
      checkOutput("hold_inst_valid", 32'(instValid), 32'd1);

      applyStimulus(400, 100, 100, 0);
      applyStimulus(3000, 60, 70, 3);
      applyStimulus(300, 30, 20, 6);
      applyStimulus(300, 90, 90, 2);

      @(posedge clk);
      #1;
      checkOutput("progress", 32'(deqCount > 500), 32'd1);
`ifdef FETCH_PERF_COUNTERS_EN
      checkOutput("perf_issued", perfIssued, hsCount);
      checkOutput("perf_dropped", perfDropped, dropCount);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
